// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter and pipelined access sequencer for one
// shared single-port synchronous SRAM with one-cycle read latency.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   req0_* / req1_*   - valid/ready request channel (we, addr, wdata) and
//                       read return (rvalid, rdata) for master 0 and master 1
//   sram_a, sram_d_in - registered SRAM address and write data
//   sram_cs/we/oe     - registered SRAM controls
//   sram_d_out        - SRAM read data, broadcast to both rdata outputs
module sram_arbiter #(
  parameter int unsigned ADR = 15,
  parameter int unsigned DAT = 8
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_we,
  input  logic [ADR-1:0] req0_addr,
  input  logic [DAT-1:0] req0_wdata,
  output logic           req0_rvalid,
  output logic [DAT-1:0] req0_rdata,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_we,
  input  logic [ADR-1:0] req1_addr,
  input  logic [DAT-1:0] req1_wdata,
  output logic           req1_rvalid,
  output logic [DAT-1:0] req1_rdata,

  output logic [ADR-1:0] sram_a,
  output logic [DAT-1:0] sram_d_in,
  input  logic [DAT-1:0] sram_d_out,
  output logic           sram_cs,
  output logic           sram_we,
  output logic           sram_oe
);

  // Round-robin pointer: index of the most recently granted port.
  logic           last_q, last_d;

  // Stage 1: issue registers driving the SRAM pins.
  logic           cs_q, cs_d;
  logic           we_q, we_d;
  logic           oe_q, oe_d;
  logic [ADR-1:0] a_q, a_d;
  logic [DAT-1:0] din_q, din_d;
  logic           tag_rd_q, tag_rd_d;
  logic           tag_port_q, tag_port_d;

  // Stage 2: return strobes, aligned with sram_d_out.
  logic           rvalid0_q, rvalid0_d;
  logic           rvalid1_q, rvalid1_d;

  logic           accept;
  logic           sel1;

  // Grant: a lone requester always wins; on contention the port that was
  // not granted last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      req0_ready = req0_valid && (!req1_valid ||  last_q);
      req1_ready = req1_valid && (!req0_valid || !last_q);
    end
    accept = req0_ready || req1_ready;
    sel1   = req1_ready;
  end

  // Next-state for pointer and both pipeline stages.
  always_comb begin
    last_d     = last_q;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    oe_d       = 1'b0;
    a_d        = a_q;
    din_d      = din_q;
    tag_rd_d   = 1'b0;
    tag_port_d = tag_port_q;

    // The read tag issued last cycle becomes this cycle's return strobe.
    rvalid0_d  = tag_rd_q && !tag_port_q;
    rvalid1_d  = tag_rd_q &&  tag_port_q;

    if (accept) begin
      last_d     = sel1;
      cs_d       = 1'b1;
      we_d       = sel1 ? req1_we : req0_we;
      oe_d       = !we_d;
      a_d        = sel1 ? req1_addr : req0_addr;
      din_d      = sel1 ? req1_wdata : req0_wdata;
      tag_rd_d   = !we_d;
      tag_port_d = sel1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      a_q        <= '0;
      din_q      <= '0;
      tag_rd_q   <= 1'b0;
      tag_port_q <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      last_q     <= last_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
      a_q        <= a_d;
      din_q      <= din_d;
      tag_rd_q   <= tag_rd_d;
      tag_port_q <= tag_port_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign sram_cs     = cs_q;
  assign sram_we     = we_q;
  assign sram_oe     = oe_q;
  assign sram_a      = a_q;
  assign sram_d_in   = din_q;

  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;

  // Read data is broadcast; only the port with rvalid set consumes it.
  assign req0_rdata  = sram_d_out;
  assign req1_rdata  = sram_d_out;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: behavioural SRAM plus a transaction-level
// reference model (grant rule, memory array, queue of expected read returns).
module tb_sram_arbiter;

  localparam int unsigned ADR = 15;
  localparam int unsigned DAT = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req0_we, req0_rvalid;
  logic [ADR-1:0] req0_addr;
  logic [DAT-1:0] req0_wdata, req0_rdata;
  logic           req1_valid, req1_ready, req1_we, req1_rvalid;
  logic [ADR-1:0] req1_addr;
  logic [DAT-1:0] req1_wdata, req1_rdata;
  logic [ADR-1:0] sram_a;
  logic [DAT-1:0] sram_d_in;
  logic [DAT-1:0] sram_d_out = '0;
  logic           sram_cs, sram_we, sram_oe;

  int n_cmp = 0;
  int n_err = 0;

  sram_arbiter #(.ADR(ADR), .DAT(DAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .sram_a(sram_a), .sram_d_in(sram_d_in), .sram_d_out(sram_d_out),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous SRAM, registered read data.
  logic [DAT-1:0] sram_mem [0:(1<<ADR)-1] = '{default: 8'h00};
  always @(posedge clk) begin
    if (sram_cs && sram_we) sram_mem[sram_a] <= sram_d_in;
    if (sram_cs && sram_oe) sram_d_out <= sram_mem[sram_a];
  end

  // ---------------- reference model ----------------
  typedef struct {
    int             due;
    bit             port;
    logic [DAT-1:0] data;
  } rsp_t;

  rsp_t           rsp_q[$];
  logic [DAT-1:0] m_mem [0:(1<<ADR)-1] = '{default: 8'h00};
  bit             m_last = 1'b1;
  int             cyc = 0;
  logic           nxt_cs = 0, nxt_we = 0, nxt_oe = 0;
  logic [ADR-1:0] nxt_a = '0;
  logic [DAT-1:0] nxt_d = '0;
  logic           exp_cs = 0, exp_we = 0, exp_oe = 0;
  logic [ADR-1:0] exp_a = '0;
  logic [DAT-1:0] exp_d = '0;
  logic           exp_rv0 = 0, exp_rv1 = 0;
  logic [DAT-1:0] exp_rdata = '0;

  // 0: no grant, 1: port 0, 2: port 1.
  function automatic int m_grant();
    if (rst) return 0;
    if (req0_valid && req1_valid) return m_last ? 1 : 2;
    if (req0_valid) return 1;
    if (req1_valid) return 2;
    return 0;
  endfunction

  // Apply the current inputs to the model, advance one clock, and publish
  // what the DUT outputs should show in the new cycle.
  task automatic tick();
    int             g;
    bit             p;
    logic           we;
    logic [ADR-1:0] a;
    logic [DAT-1:0] wd;
    rsp_t           r;
    g = m_grant();
    if (rst) begin
      m_last = 1'b1;
      rsp_q.delete();
      nxt_cs = 0; nxt_we = 0; nxt_oe = 0; nxt_a = '0; nxt_d = '0;
    end else if (g != 0) begin
      p  = (g == 2);
      we = p ? req1_we : req0_we;
      a  = p ? req1_addr : req0_addr;
      wd = p ? req1_wdata : req0_wdata;
      m_last = p;
      nxt_cs = 1; nxt_we = we; nxt_oe = !we; nxt_a = a; nxt_d = wd;
      if (we) m_mem[a] = wd;
      else    rsp_q.push_back('{due: cyc + 2, port: p, data: m_mem[a]});
    end else begin
      nxt_cs = 0; nxt_we = 0; nxt_oe = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_cs = nxt_cs; exp_we = nxt_we; exp_oe = nxt_oe;
    exp_a  = nxt_a;  exp_d  = nxt_d;
    exp_rv0 = 0; exp_rv1 = 0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (r.port) exp_rv1 = 1; else exp_rv0 = 1;
      exp_rdata = r.data;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin #1; tick(); end
  endtask

  task automatic do_reset();
    rst = 1; #1; tick(); rst = 0;
  endtask

  task automatic do_write(input bit p, input logic [ADR-1:0] a, input logic [DAT-1:0] d);
    bit done = 0;
    if (p) begin req1_valid = 1; req1_we = 1; req1_addr = a; req1_wdata = d; end
    else   begin req0_valid = 1; req0_we = 1; req0_addr = a; req0_wdata = d; end
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      done = p ? req1_ready : req0_ready;
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL write_accept: port %0d not accepted within 8 cycles", p); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        n_err++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
      end
      tick();
      n_cmp++;
      if ({sram_cs, sram_we, sram_oe, sram_a, sram_d_in} !== '0) begin
        n_err++; $display("FAIL reset_pins: got cs%b we%b oe%b a=%h d=%h expected all 0",
                          sram_cs, sram_we, sram_oe, sram_a, sram_d_in);
      end
      n_cmp++;
      if ({req0_rvalid, req1_rvalid} !== 2'b00) begin
        n_err++; $display("FAIL reset_rvalid: got %b expected 00", {req0_rvalid, req1_rvalid});
      end
    end
    rst = 0; req0_valid = 0; req1_valid = 0;
    idle(1);
  endtask

  task automatic test_write_read();
    req0_valid = 1; req0_we = 1; req0_addr = 15'h0100; req0_wdata = 8'h5A;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b expected 1", req0_ready); end
    tick();
    req0_we = 0;
    #1;
    n_cmp++;
    if ({sram_cs, sram_we, sram_oe, sram_a, sram_d_in} !== {3'b110, 15'h0100, 8'h5A}) begin
      n_err++; $display("FAIL wr_pins: got cs%b we%b oe%b a=%h d=%h expected cs1 we1 oe0 a=0100 d=5a",
                        sram_cs, sram_we, sram_oe, sram_a, sram_d_in);
    end
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %b expected 1", req0_ready); end
    tick();
    req0_valid = 0;
    #1;
    n_cmp++;
    if ({sram_cs, sram_we, sram_oe, sram_a} !== {3'b101, 15'h0100}) begin
      n_err++; $display("FAIL rd_pins: got cs%b we%b oe%b a=%h expected cs1 we0 oe1 a=0100",
                        sram_cs, sram_we, sram_oe, sram_a);
    end
    tick();
    #1;
    n_cmp++;
    if ({req0_rvalid, req1_rvalid, req0_rdata} !== {2'b10, 8'h5A}) begin
      n_err++; $display("FAIL rd_return: got rv0=%b rv1=%b rdata=%h expected 1 0 5a",
                        req0_rvalid, req1_rvalid, req0_rdata);
    end
    tick();
    #1;
    n_cmp++;
    if (req0_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_one_shot: got rv0=%b expected 0", req0_rvalid); end
    tick();
  endtask

  task automatic test_contention();
    logic exp0;
    do_write(0, 15'h0010, 8'h11);
    do_write(1, 15'h0020, 8'h22);
    idle(2);
    do_reset();
    req0_we = 0; req0_addr = 15'h0010;
    req1_we = 0; req1_addr = 15'h0020;
    for (int i = 0; i < 8; i++) begin
      req0_valid = (i < 6); req1_valid = (i < 6);
      exp0 = ((i % 2) == 0);
      #1;
      if (i < 6) begin
        n_cmp++;
        if ({req0_ready, req1_ready} !== {exp0, !exp0}) begin
          n_err++; $display("FAIL rr_grant[%0d]: got r0=%b r1=%b expected %b %b",
                            i, req0_ready, req1_ready, exp0, !exp0);
        end
      end
      if (i >= 2) begin
        n_cmp++;
        if ({req0_rvalid, req1_rvalid} !== {exp0, !exp0}) begin
          n_err++; $display("FAIL rr_rvalid[%0d]: got %b%b expected %b%b",
                            i, req0_rvalid, req1_rvalid, exp0, !exp0);
        end
        n_cmp++;
        if ((exp0 ? req0_rdata : req1_rdata) !== (exp0 ? 8'h11 : 8'h22)) begin
          n_err++; $display("FAIL rr_rdata[%0d]: got %h expected %h",
                            i, exp0 ? req0_rdata : req1_rdata, exp0 ? 8'h11 : 8'h22);
        end
      end
      tick();
    end
  endtask

  task automatic test_port1_stream();
    logic [ADR-1:0] adrs [4] = '{15'h0010, 15'h0020, 15'h0100, 15'h0010};
    logic [DAT-1:0] dats [4] = '{8'h11, 8'h22, 8'h5A, 8'h11};
    req1_we = 0;
    for (int i = 0; i < 7; i++) begin
      req1_valid = (i < 4);
      if (i < 4) req1_addr = adrs[i];
      #1;
      if (i < 4) begin
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
          n_err++; $display("FAIL solo_ready[%0d]: got r0=%b r1=%b expected 0 1", i, req0_ready, req1_ready);
        end
      end
      if (i >= 2 && i < 6) begin
        n_cmp++;
        if ({req1_rvalid, req1_rdata} !== {1'b1, dats[i-2]}) begin
          n_err++; $display("FAIL solo_return[%0d]: got rv1=%b rdata=%h expected 1 %h",
                            i, req1_rvalid, req1_rdata, dats[i-2]);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (req1_rvalid !== 1'b0) begin n_err++; $display("FAIL solo_end: got rv1=%b expected 0", req1_rvalid); end
      end
      n_cmp++;
      if (req0_rvalid !== 1'b0) begin n_err++; $display("FAIL solo_rv0[%0d]: got %b expected 0", i, req0_rvalid); end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    req0_valid = 1; req0_we = 0; req0_addr = 15'h0020;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rstfl_accept: got %b expected 1", req0_ready); end
    tick();
    rst = 1;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rstfl_ready: got %b expected 0", req0_ready); end
    n_cmp++;
    if ({sram_cs, sram_oe} !== 2'b11) begin
      n_err++; $display("FAIL rstfl_issue: got cs%b oe%b expected 1 1", sram_cs, sram_oe);
    end
    tick();
    rst = 0; req0_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({req0_rvalid, req1_rvalid} !== 2'b00) begin
        n_err++; $display("FAIL rstfl_rvalid[%0d]: got %b%b expected 00", i, req0_rvalid, req1_rvalid);
      end
      n_cmp++;
      if ({sram_cs, sram_we, sram_oe, sram_a, sram_d_in} !== '0) begin
        n_err++; $display("FAIL rstfl_pins[%0d]: got cs%b we%b oe%b a=%h d=%h expected all 0",
                          i, sram_cs, sram_we, sram_oe, sram_a, sram_d_in);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back_raw();
    req0_valid = 1; req0_we = 0; req0_addr = 15'h0010;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_err++; $display("FAIL raw_first: got %b expected 1", req0_ready); end
    tick();
    req0_addr = 15'h7FFF;
    req1_valid = 1; req1_we = 1; req1_addr = 15'h7FFF; req1_wdata = 8'hC3;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL raw_grant: got r0=%b r1=%b expected 0 1", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 0;
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_err++; $display("FAIL raw_read_ready: got %b expected 1", req0_ready); end
    n_cmp++;
    if ({req0_rvalid, req0_rdata} !== {1'b1, 8'h11}) begin
      n_err++; $display("FAIL raw_prev_return: got rv0=%b rdata=%h expected 1 11", req0_rvalid, req0_rdata);
    end
    tick();
    req0_valid = 0;
    #1;
    tick();
    #1;
    n_cmp++;
    if ({req0_rvalid, req1_rvalid, req0_rdata} !== {2'b10, 8'hC3}) begin
      n_err++; $display("FAIL raw_return: got rv0=%b rv1=%b rdata=%h expected 1 0 c3",
                        req0_rvalid, req1_rvalid, req0_rdata);
    end
    tick();
  endtask

  task automatic test_random();
    bit             pv [2] = '{0, 0};
    int             g;
    logic [ADR-1:0] a;
    do_reset();
    for (int i = 0; i < 404; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && i < 400 && $urandom_range(0, 99) < 65) begin
          pv[p] = 1;
          a = ($urandom_range(0, 1) == 1) ? ADR'(15'h7FF8 + 15'($urandom_range(0, 7)))
                                          : ADR'($urandom_range(0, 7));
          if (p == 0) begin
            req0_we = 1'($urandom_range(0, 1)); req0_addr = a; req0_wdata = 8'($urandom);
          end else begin
            req1_we = 1'($urandom_range(0, 1)); req1_addr = a; req1_wdata = 8'($urandom);
          end
        end
      end
      req0_valid = pv[0]; req1_valid = pv[1];
      #1;
      g = m_grant();
      n_cmp++;
      if ({req0_ready, req1_ready} !== {1'(g == 1), 1'(g == 2)}) begin
        n_err++; $display("FAIL rnd_grant cyc%0d: got r0=%b r1=%b expected %b %b",
                          cyc, req0_ready, req1_ready, g == 1, g == 2);
      end
      n_cmp++;
      if ({sram_cs, sram_we, sram_oe} !== {exp_cs, exp_we, exp_oe}) begin
        n_err++; $display("FAIL rnd_ctrl cyc%0d: got cs%b we%b oe%b expected cs%b we%b oe%b",
                          cyc, sram_cs, sram_we, sram_oe, exp_cs, exp_we, exp_oe);
      end
      n_cmp++;
      if ({sram_a, sram_d_in} !== {exp_a, exp_d}) begin
        n_err++; $display("FAIL rnd_addr_data cyc%0d: got a=%h d=%h expected a=%h d=%h",
                          cyc, sram_a, sram_d_in, exp_a, exp_d);
      end
      n_cmp++;
      if ({req0_rvalid, req1_rvalid} !== {exp_rv0, exp_rv1}) begin
        n_err++; $display("FAIL rnd_rvalid cyc%0d: got %b%b expected %b%b",
                          cyc, req0_rvalid, req1_rvalid, exp_rv0, exp_rv1);
      end
      if (exp_rv0 || exp_rv1) begin
        n_cmp++;
        if ((exp_rv1 ? req1_rdata : req0_rdata) !== exp_rdata) begin
          n_err++; $display("FAIL rnd_rdata cyc%0d: got %h expected %h",
                            cyc, exp_rv1 ? req1_rdata : req0_rdata, exp_rdata);
        end
      end
      tick();
      if (g == 1) pv[0] = 0;
      if (g == 2) pv[1] = 0;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_contention();
    test_port1_stream();
    test_reset_inflight();
    test_back_to_back_raw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the shared single-port synchronous SRAM. It accepts independent read/write requests from two masters, port 0 (CPU bus bridge) and port 1 (DMA/video fetch), and grants one per cycle with round-robin fairness. It drives the SRAM's registered `CS`/`WE`/`OE`/`a`/`d_in` pins and routes the one-cycle-latency read data back to the requesting port. Accesses are fully pipelined, so the block sustains one access per cycle.

## Interface
Parameters:
- `ADR`, default 15: address width; must match the SRAM instance.
- `DAT`, default 8: data width.

Ports:
- `clk` in, 1: the single clock; all state is updated on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `req0_valid` in, 1: port 0 has a request pending.
- `req0_ready` out, 1: port 0's request is accepted this cycle.
- `req0_we` in, 1: 1 = write, 0 = read.
- `req0_addr` in, `ADR`: request address.
- `req0_wdata` in, `DAT`: write data.
- `req0_rvalid` out, 1: read data valid for port 0.
- `req0_rdata` out, `DAT`: read data.
- `req1_*`: same set as `req0_*`, for port 1.
- `sram_a` out, `ADR`: SRAM address.
- `sram_d_in` out, `DAT`: SRAM write data.
- `sram_d_out` in, `DAT`: SRAM read data.
- `sram_cs`, `sram_we`, `sram_oe` out, 1 each: SRAM controls.

## Operation
- A request is accepted on a rising edge where `reqX_valid && reqX_ready`.
- Grant, combinational from the valid inputs and the round-robin pointer `last`:
  - One port valid: that port is granted.
  - Both ports valid: the port with index != `last` is granted.
  - On every accept, `last` updates to the granted port.
- `req0_ready` and `req1_ready` are never both 1. Both are 0 while `rst` = 1.
- `reqX_ready` does not depend on `reqX_ready` of the other port being sampled. A requester must hold valid, we, addr and wdata stable until it is accepted.
- Stage 1 (issue registers), loaded on accept:
  - `sram_cs` = 1
  - `sram_we` = we
  - `sram_oe` = !we
  - `sram_a` = addr
  - `sram_d_in` = wdata
  - A tag records the port and whether the access is a read.
- Cycle with no accept: `sram_cs`/`sram_we`/`sram_oe` = 0, while `sram_a` and `sram_d_in` hold their previous values.
- Stage 2 (return registers): for a read, `rvalid` is set for the tagged port for one cycle. `req0_rdata` = `req1_rdata` = `sram_d_out`, a broadcast that is meaningful only when qualified by `rvalid`.
- Writes produce no response. Ordering is strictly in-order, so a read accepted the cycle after a write to the same address returns the new data.
- `sram_we` and `sram_oe` are never both 1.
- Reset:
  - `last` = 1, so port 0 wins the first contention.
  - All `sram_*` outputs = 0.
  - Both `rvalid` = 0 and both tags are cleared.
  - In-flight reads are dropped and their `rvalid` never asserts.
  - A request presented during reset is not accepted.
  - An SRAM write already issued in stage 1 when `rst` rises completes only if its SRAM edge precedes the reset edge. Otherwise the cleared `sram_cs` cancels it.

## Timing
- Request accepted at the end of cycle N → SRAM pins driven during cycle N+1 → SRAM samples at the end of N+1.
- Read: `reqX_rvalid` = 1 for exactly cycle N+2, with `rdata` = mem[addr].
- Read latency is 2 cycles from accept.
- Throughput is 1 access/cycle. Back-to-back accepts, including alternating ports, need no bubbles.
- Under continuous contention the grants strictly alternate 0,1,0,1…
- A solo requester is granted every cycle regardless of `last`.
- `ready` has a combinational path from both `valid`s. There is no combinational path from `sram_d_out` to any control output.

## Test plan
- Reset, then idle for 3 cycles → all `sram_*` = 0, both `ready` = 0 during `rst`, both `rvalid` = 0.
- Port 0: write 0x5A to 0x0100, then read 0x0100 in the next cycle → `sram_we` pulse in cycle 2, `sram_oe` in cycle 3, `req0_rvalid` = 1 in cycle 4 with `rdata` = 0x5A, `req1_rvalid` stays 0.
- Both ports hold read requests for 6 cycles (port 0 at 0x0010, port 1 at 0x0020; memory preloaded with 0x11/0x22) → grants after reset are 0,1,0,1,0,1. `rvalid`s alternate with data 0x11/0x22, each 2 cycles after its accept.
- Port 1 alone issues 4 consecutive reads → accepted every cycle; `req1_rvalid` is high for 4 consecutive cycles with in-order data.
- Port 0 read accepted, then `rst` asserted the next cycle → `req0_rvalid` never asserts and outputs return to reset values.
- Port 1 write 0xC3 to 0x7FFF and port 0 read 0x7FFF presented simultaneously after a port-0 grant → port 1 is granted first; the following port-0 read returns 0xC3.
